// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 codes and lane helpers for the MEM-stage LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LB, LBU: be_gen = 4'b0001 << off;
            LH, LHU: be_gen = 4'b0011 << off;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3)
            SB:      wdata_gen = {4{data[7:0]}};
            SH:      wdata_gen = {2{data[15:0]}};
            default: wdata_gen = data;
        endcase
    endfunction

    // Unsupported width code, or an address not aligned to the access size.
    function automatic logic access_illegal(input logic is_store, input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic bad_f3;
        logic bad_al;
        if (is_store)
            bad_f3 = !(funct3 == SB || funct3 == SH || funct3 == SW);
        else
            bad_f3 = !(funct3 == LB || funct3 == LH || funct3 == LW ||
                       funct3 == LBU || funct3 == LHU);
        case (funct3[1:0])
            2'b01:   bad_al = off[0];
            2'b10:   bad_al = (off != 2'b00);
            default: bad_al = 1'b0;
        endcase
        access_illegal = bad_f3 | bad_al;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ============================================================================
// Module      : lsu_if
// Description : Data-memory request/grant/response bus between LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_if #(
    parameter int AW = 32
);
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [3:0]    dmem_be_o;
    logic [31:0]   dmem_wdata_o;
    logic          dmem_gnt_i;
    logic          dmem_rvalid_i;
    logic [31:0]   dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module      : lsu_load_align
// Description : Extracts the addressed byte/half/word and sign- or zero-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (off_i)
            2'd1:    w_byte = word_i[15:8];
            2'd2:    w_byte = word_i[23:16];
            2'd3:    w_byte = word_i[31:24];
            default: w_byte = word_i[7:0];
        endcase
        w_half = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            LB:      data_o = {{24{w_byte[7]}}, w_byte};
            LBU:     data_o = {24'd0, w_byte};
            LH:      data_o = {{16{w_half[15]}}, w_half};
            LHU:     data_o = {16'd0, w_half};
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
// ============================================================================
// Module      : lsu_mem_stage
// Description : MEM-stage load/store unit: dmem handshake, stall, load alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          mem_rd_i,
    input  logic          mem_wr_i,
    input  logic [2:0]    funct3_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   st_data_i,
    input  logic          flush_i,
    lsu_if.master         dmem,
    output logic [31:0]   ld_data_o,
    output logic          ld_valid_o,
    output logic          stall_o,
    output logic          misalign_o
);

    lsu_state_e    r_state;
    lsu_state_e    w_next;
    logic          r_req;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic          r_flushed;
    logic [31:0]   r_ld_data;
    logic          r_ld_valid;

    logic          w_op;
    logic          w_illegal;
    logic          w_launch;
    logic [31:0]   w_aligned;

    assign w_op      = mem_rd_i | mem_wr_i;
    assign w_illegal = access_illegal(mem_wr_i, funct3_i, addr_i[1:0]);
    assign w_launch  = (r_state == ST_IDLE) && (w_next == ST_REQ);

    lsu_load_align u_align (
        .word_i   (dmem.dmem_rdata_i),
        .funct3_i (r_funct3),
        .off_i    (r_off),
        .data_o   (w_aligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Launch is gated by reset so nothing stalls or flags while reset is held.
    always_comb begin
        w_next     = r_state;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_op && !flush_i && !i_rst) begin
                    if (w_illegal) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        w_next  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (dmem.dmem_gnt_i)
                    w_next = r_we ? ST_DONE : ST_WAIT_R;
                else if (flush_i)
                    w_next = ST_IDLE;
            end
            ST_WAIT_R: begin
                stall_o = 1'b1;
                if (dmem.dmem_rvalid_i)
                    w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_flushed  <= 1'b0;
            r_ld_data  <= 32'd0;
            r_ld_valid <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_req     <= 1'b1;
                        r_we      <= mem_wr_i;
                        r_addr    <= {addr_i[AW-1:2], 2'b00};
                        r_be      <= be_gen(funct3_i, addr_i[1:0]);
                        r_wdata   <= wdata_gen(funct3_i, st_data_i);
                        r_funct3  <= funct3_i;
                        r_off     <= addr_i[1:0];
                        r_flushed <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_gnt_i || flush_i)
                        r_req <= 1'b0;
                    // A flush coinciding with the grant cannot cancel a committed access.
                    if (dmem.dmem_gnt_i && flush_i)
                        r_flushed <= 1'b1;
                end
                ST_WAIT_R: begin
                    if (flush_i)
                        r_flushed <= 1'b1;
                    if (dmem.dmem_rvalid_i) begin
                        r_ld_data  <= w_aligned;
                        r_ld_valid <= !(r_flushed || flush_i);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req_o   = r_req;
    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = r_addr;
    assign dmem.dmem_be_o    = r_be;
    assign dmem.dmem_wdata_o = r_wdata;
    assign ld_data_o         = r_ld_data;
    assign ld_valid_o        = r_ld_valid;

endmodule

`default_nettype wire

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

MEM-stage load/store unit that drives the data-memory request/grant/response interface and produces the aligned, extended load data consumed by the MEM/WB pipeline register. It sits between the EX/MEM register and data memory. It holds the pipeline through the hazard unit with `stall_o` until the memory transaction completes. It also generates byte enables and replicated store data, and flags misaligned or unsupported accesses.

## Interface
- `AW`, 32, data-memory byte-address width.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `mem_rd_i`  in  1  load in MEM stage.
- `mem_wr_i`  in  1  store in MEM stage; has priority if both `mem_rd_i` and `mem_wr_i` are set.
- `funct3_i`  in  3  RV32I width/sign code.
- `addr_i`  in  AW  byte address from the ALU.
- `st_data_i`  in  32  rs2 store data.
- `flush_i`  in  1  kill the current MEM-stage instruction.
- `dmem_req_o`  out  1  request valid.
- `dmem_we_o`  out  1  1 = write.
- `dmem_addr_o`  out  AW  word-aligned address; bits [1:0] = 0.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  replicated store data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  32  read word.
- `ld_data_o`  out  32  aligned, extended load result to MEM/WB.
- `ld_valid_o`  out  1  one-cycle pulse when `ld_data_o` is new.
- `stall_o`  out  1  freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- `misalign_o`  out  1  one-cycle pulse: misaligned access or unsupported funct3.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- **IDLE**
  - If an operation is present, legal, and `flush_i` is 0: latch the word address, `dmem_be_o`, `dmem_wdata_o`, `dmem_we_o`, `funct3` and `addr[1:0]` into registers, then go to REQ.
  - `stall_o` = 1 combinationally in this cycle.
- **REQ**
  - `dmem_req_o` = 1; all `dmem_*` outputs are driven from the latched registers.
  - On `dmem_gnt_i`: a store goes to DONE, a load goes to WAIT_R.
  - `flush_i` without `dmem_gnt_i` → IDLE; `dmem_req_o` drops the next cycle.
  - `dmem_rvalid_i` is ignored in REQ.
- **WAIT_R**
  - `dmem_req_o` = 0.
  - On `dmem_rvalid_i`: register the aligned result into `ld_data_o`, then go to DONE.
  - `flush_i` here is remembered and suppresses the `ld_valid_o` pulse. The transaction still completes because memory is committed.
- **DONE**
  - `stall_o` = 0; `ld_valid_o` = 1 for loads only; next state is IDLE.
  - The operation inputs seen in DONE belong to the finished instruction and are ignored.
- **Store byte enables and data**
  - SB: `be` = 4'b0001 << `addr[1:0]`, data = byte ×4.
  - SH: `be` = 4'b0011 << `addr[1:0]`, data = half ×2.
  - SW: `be` = 4'b1111.
- **Load extraction and extension**
  - LB/LBU: byte at `addr[1:0]`, sign-/zero-extended.
  - LH/LHU: half at `addr[1]`, sign-/zero-extended.
  - LW: the full word.
- **Illegal accesses**
  - Misaligned: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Unsupported funct3: loads 011/110/111; stores other than 000/001/010.
  - Either case in IDLE: `misalign_o` = 1 combinationally, no request, no stall, `ld_data_o` unchanged.
- Reset (asynchronous, any state): state → IDLE; `ld_data_o`, `ld_valid_o`, `dmem_*` registers and the flush flag → 0. An in-flight transaction is abandoned.

## Timing
- Store, grant in the first REQ cycle: cycle 0 IDLE (stall), cycle 1 REQ+gnt (stall), cycle 2 DONE. Two stall cycles.
- Load, rvalid one cycle after gnt: IDLE, REQ, WAIT_R, DONE. Three stall cycles; `ld_data_o`/`ld_valid_o` are valid in DONE.
- Each extra cycle of gnt or rvalid delay adds one stall cycle. There is no timeout.
- `dmem_*` outputs are registered; `stall_o` and `misalign_o` are combinational from state and inputs.
- `ld_data_o` holds its value until the next completed load.

## Structure
- `lsu_pkg`:
  - `lsu_state_e` enum.
  - funct3 localparams: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - `function be_gen(funct3, off)`.
- Sub-module `lsu_load_align`: combinational extract/extend of a 32-bit word, driven by `funct3` and the 2-bit offset.

## Test plan
- **SW** addr 0x104, data 0xDEADBEEF, gnt immediate → `dmem_addr_o` 0x104, `be` 1111, `we` 1; `stall_o` high for exactly 2 cycles.
- **LB** addr 0x203, rdata 0x80FF_0000, rvalid 2 cycles after gnt → `ld_data_o` 0xFFFFFF80, `ld_valid_o` 1 cycle; 4 stall cycles.
- **SB** addr 0x102, data 0x000000A5 → `be` 0100, `wdata` 0xA5A5A5A5. **LHU** addr 0x102, rdata 0x8001_1234 → `ld_data_o` 0x00008001.
- **LW** addr 0x101 → `misalign_o` pulse, `dmem_req_o` stays 0, `stall_o` 0, `ld_data_o` unchanged.
- **Flush/reset:** `flush_i` in REQ before gnt → IDLE, no `ld_valid_o`. `flush_i` in WAIT_R → rvalid accepted, `ld_valid_o` suppressed. `i_rst` asserted mid-WAIT_R → all outputs 0 immediately.
